// File: rtl/alu_pkg.sv
// Shared constants for the 32-bit execute-stage ALU: opcode map and flag bit positions.
package alu_pkg;

    // Operation select codes carried on opCode
    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_XOR   = 6'h04;
    localparam logic [5:0] OP_NOR   = 6'h05;
    localparam logic [5:0] OP_SLL   = 6'h06;
    localparam logic [5:0] OP_SRL   = 6'h07;
    localparam logic [5:0] OP_SRA   = 6'h08;
    localparam logic [5:0] OP_SLT   = 6'h09;
    localparam logic [5:0] OP_SLTU  = 6'h0A;
    localparam logic [5:0] OP_PASSA = 6'h0B;
    localparam logic [5:0] OP_PASSB = 6'h0C;

    // Bit positions inside the 4-bit status vector S
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

endpackage : alu_pkg

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sub=1 computes a + ~b + 1 so carry means "no borrow".
module alu_addsub #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         carry,
    output logic         overflow
);

    logic [N-1:0] b_eff;
    logic [N:0]   full;

    // Invert b for subtraction; the +1 comes in through the low carry-in
    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};

    assign sum      = full[N-1:0];
    assign carry    = full[N];
    // Signed overflow: operands of equal sign produced a result of the other sign
    assign overflow = (a[N-1] == b_eff[N-1]) && (sum[N-1] != a[N-1]);

endmodule : alu_addsub

// File: rtl/alu_32.sv
// 32-bit execute-stage ALU: combinational result/flag selection, one register stage.
// No handshake: every clock samples a, b, opCode and the result appears on out/S
// one cycle later; a new operation may be issued every cycle.
module alu_32
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [5:0]   opCode,
    output logic [N-1:0] out,
    output logic [3:0]   S
);

    localparam int SHW = $clog2(N);

    logic [SHW-1:0] shamt;
    logic           use_sub;
    logic [N-1:0]   add_sum;
    logic           add_carry;
    logic           add_ovf;

    logic [N-1:0]   out_d, out_q;
    logic [3:0]     s_d, s_q;
    logic           c_d, v_d;

    // Only the low bits of b select the shift distance
    assign shamt = b[SHW-1:0];

    // Comparisons reuse the subtractor: SLT from N^V, SLTU from borrow
    assign use_sub = (opCode == OP_SUB) || (opCode == OP_SLT) || (opCode == OP_SLTU);

    alu_addsub #(.N(N)) u_addsub (
        .a        (a),
        .b        (b),
        .sub      (use_sub),
        .sum      (add_sum),
        .carry    (add_carry),
        .overflow (add_ovf)
    );

    // Result mux; C and V are meaningful only for ADD and SUB
    always_comb begin
        out_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (opCode)
            OP_ADD: begin
                out_d = add_sum;
                c_d   = add_carry;
                v_d   = add_ovf;
            end
            OP_SUB: begin
                out_d = add_sum;
                c_d   = add_carry;
                v_d   = add_ovf;
            end
            OP_AND:   out_d = a & b;
            OP_OR:    out_d = a | b;
            OP_XOR:   out_d = a ^ b;
            OP_NOR:   out_d = ~(a | b);
            OP_SLL:   out_d = a << shamt;
            OP_SRL:   out_d = a >> shamt;
            OP_SRA:   out_d = $signed(a) >>> shamt;
            OP_SLT:   out_d = {{(N-1){1'b0}}, add_sum[N-1] ^ add_ovf};
            OP_SLTU:  out_d = {{(N-1){1'b0}}, ~add_carry};
            OP_PASSA: out_d = a;
            OP_PASSB: out_d = b;
            default:  out_d = '0;
        endcase
    end

    // Assemble the flag vector from the selected result
    always_comb begin
        s_d         = 4'b0000;
        s_d[FLAG_C] = c_d;
        s_d[FLAG_Z] = (out_d == '0);
        s_d[FLAG_N] = out_d[N-1];
        s_d[FLAG_V] = v_d;
    end

    // Output register; reset clears result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            s_q   <= 4'b0000;
        end else begin
            out_q <= out_d;
            s_q   <= s_d;
        end
    end

    assign out = out_q;
    assign S   = s_q;

endmodule : alu_32

// File: tb/tb_alu_32.sv
// Self-checking bench for alu_32: directed tables plus randomized traffic scored
// against an arithmetic reference model.
module tb_alu_32;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  op_code;
  logic [31:0] out;
  logic [3:0]  s;

  int checks;
  int failures;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [3:0]  s;
  } vec_t;

  logic [35:0] exp_q[$];

  alu_32 dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .opCode (op_code),
    .out    (out),
    .S      (s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference model: {S, out} from plain integer arithmetic
  function automatic logic [35:0] model(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
    longint sa, sb, sr;
    logic [31:0] r;
    logic c, v;
    int sh;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    sh = int'(bv % 32);
    r = 32'd0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      6'h00: begin
        r  = av + bv;
        c  = (longint'(av) + longint'(bv)) >= 64'sd4294967296;
        sr = sa + sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      6'h01: begin
        r  = av - bv;
        c  = (av >= bv);
        sr = sa - sb;
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      6'h02: r = av & bv;
      6'h03: r = av | bv;
      6'h04: r = av ^ bv;
      6'h05: r = ~(av | bv);
      6'h06: r = av << sh;
      6'h07: r = av >> sh;
      6'h08: r = 32'(longint'(sa / (64'sd1 << sh)) - ((sa < 0 && (sa % (64'sd1 << sh)) != 0) ? 1 : 0));
      6'h09: r = (sa < sb) ? 32'd1 : 32'd0;
      6'h0A: r = (av < bv) ? 32'd1 : 32'd0;
      6'h0B: r = av;
      6'h0C: r = bv;
      default: r = 32'd0;
    endcase
    return {c, (r == 32'd0), r[31], v, r};
  endfunction

  // driver: apply one operation at the falling edge, return 1ns after the next rising edge
  task automatic drive_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    op_code = op;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a = 32'd7;
    b = 32'd2;
    op_code = 6'h00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out !== 32'd0 || s !== 4'b0000) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: out=%h S=%b expected out=0 S=0000", i, out, s);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'd9 || s !== 4'b0000) begin
      failures++;
      $display("FAIL reset_release: out=%h S=%b expected out=9 S=0000", out, s);
    end
    // reset asserted mid-stream overrides the in-flight operation
    @(negedge clk);
    rst = 1'b1;
    op_code = 6'h05;
    @(posedge clk);
    #1;
    checks++;
    if (out !== 32'd0 || s !== 4'b0000) begin
      failures++;
      $display("FAIL reset_override: out=%h S=%b expected out=0 S=0000", out, s);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_op_sweep;
    vec_t v[$];
    v.push_back('{6'h00, 32'd7, 32'd2, 32'h00000009, 4'b0000});
    v.push_back('{6'h01, 32'd7, 32'd2, 32'h00000005, 4'b1000});
    v.push_back('{6'h02, 32'd7, 32'd2, 32'h00000002, 4'b0000});
    v.push_back('{6'h03, 32'd7, 32'd2, 32'h00000007, 4'b0000});
    v.push_back('{6'h04, 32'd7, 32'd2, 32'h00000005, 4'b0000});
    v.push_back('{6'h05, 32'd7, 32'd2, 32'hFFFFFFF8, 4'b0010});
    v.push_back('{6'h06, 32'd7, 32'd2, 32'h0000001C, 4'b0000});
    v.push_back('{6'h07, 32'd7, 32'd2, 32'h00000001, 4'b0000});
    v.push_back('{6'h08, 32'd7, 32'd2, 32'h00000001, 4'b0000});
    v.push_back('{6'h09, 32'd7, 32'd2, 32'h00000000, 4'b0100});
    v.push_back('{6'h0A, 32'd7, 32'd2, 32'h00000000, 4'b0100});
    v.push_back('{6'h0B, 32'd7, 32'd2, 32'h00000007, 4'b0000});
    v.push_back('{6'h0C, 32'd7, 32'd2, 32'h00000002, 4'b0000});
    v.push_back('{6'h3F, 32'd7, 32'd2, 32'h00000000, 4'b0100});
    foreach (v[i]) begin
      drive_op(v[i].op, v[i].a, v[i].b);
      checks++;
      if (out !== v[i].out || s !== v[i].s) begin
        failures++;
        $display("FAIL op_sweep op=%h: out=%h S=%b expected out=%h S=%b", v[i].op, out, s, v[i].out, v[i].s);
      end
    end
  endtask

  task automatic test_flags;
    vec_t v[$];
    v.push_back('{6'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 4'b1010});
    v.push_back('{6'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011});
    v.push_back('{6'h01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b1001});
    v.push_back('{6'h00, 32'h00000000, 32'h00000000, 32'h00000000, 4'b0100});
    v.push_back('{6'h01, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1100});
    v.push_back('{6'h01, 32'h00000002, 32'h00000007, 32'hFFFFFFFB, 4'b0010});
    v.push_back('{6'h00, 32'h80000004, 32'h00000001, 32'h80000005, 4'b0010});
    v.push_back('{6'h08, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b0010});
    v.push_back('{6'h09, 32'h80000000, 32'h00000001, 32'h00000001, 4'b0000});
    v.push_back('{6'h0A, 32'h80000000, 32'h00000001, 32'h00000000, 4'b0100});
    v.push_back('{6'h06, 32'h00000005, 32'h00000000, 32'h00000005, 4'b0000});
    v.push_back('{6'h07, 32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000});
    v.push_back('{6'h06, 32'h00000001, 32'h00000021, 32'h00000002, 4'b0000});
    v.push_back('{6'h08, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 4'b0010});
    foreach (v[i]) begin
      drive_op(v[i].op, v[i].a, v[i].b);
      checks++;
      if (out !== v[i].out || s !== v[i].s) begin
        failures++;
        $display("FAIL flags op=%h a=%h b=%h: out=%h S=%b expected out=%h S=%b",
                 v[i].op, v[i].a, v[i].b, out, s, v[i].out, v[i].s);
      end
    end
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // issue one op per cycle, scoring each result as the next op is applied
  task automatic test_back_to_back(input int n);
    logic [5:0]  op;
    logic [31:0] av, bv;
    logic [35:0] exp_v;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        if (out !== exp_v[31:0] || s !== exp_v[35:32]) begin
          failures++;
          $display("FAIL back_to_back #%0d: out=%h S=%b expected out=%h S=%b",
                   i - 1, out, s, exp_v[31:0], exp_v[35:32]);
        end
      end
      if (i < n) begin
        op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(13, 63)) : 6'($urandom_range(0, 12));
        av = rand_operand();
        bv = rand_operand();
        op_code = op;
        a = av;
        b = bv;
        exp_q.push_back(model(op, av, bv));
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    a = '0;
    b = '0;
    op_code = '0;
    test_reset();
    test_op_sweep();
    test_flags();
    test_back_to_back(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_32

// File: doc/alu_32.md
Name: alu_32

Overview:
- 32-bit integer ALU with registered outputs, operating on two operands `a` and `b` under a 6-bit opcode.
- Produces a 32-bit result and a 4-bit status flag vector (carry, zero, negative, overflow).
- Sits in the execute stage of the datapath.
- Inputs are sampled every clock; result and flags appear one cycle later.

Parameters:
- N, 32, operand/result width. Behaviour is specified for N=32; shift amount width is clog2(N).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  N  operand A
- b  input  N  operand B (shift amount for shift ops = b[4:0])
- opCode  input  6  operation select
- out  output  N  registered result
- S  output  4  registered flags: S[3]=C carry, S[2]=Z zero, S[1]=N negative, S[0]=V overflow

Behaviour:
- Latency: 1 cycle.
  - `out` and `S` update on the rising clk edge after inputs are sampled.
  - No handshake; a new operation can start every cycle.
- Reset: rst=1 at a clock edge forces out=0 and S=4'b0000. It overrides any operation in flight. The first valid result appears one cycle after rst deasserts.
- Opcode map (6'hxx); all other codes are undefined:

  | Code | Op | Result |
  |---|---|---|
  | 00 | ADD | a+b |
  | 01 | SUB | a-b |
  | 02 | AND | a&b |
  | 03 | OR | a\|b |
  | 04 | XOR | a^b |
  | 05 | NOR | ~(a\|b) |
  | 06 | SLL | a<<b[4:0] |
  | 07 | SRL | logical a>>b[4:0] |
  | 08 | SRA | arithmetic a>>>b[4:0] |
  | 09 | SLT | signed a<b ? 1 : 0 |
  | 0A | SLTU | unsigned a<b ? 1 : 0 |
  | 0B | PASSA | a |
  | 0C | PASSB | b |

- Undefined opcodes: out=0; flags computed from that result as for logic ops (Z=1, N=0, C=0, V=0).
- Flags:
  - Z = (result==0), for every opcode.
  - N = result[31], for every opcode.
  - C:
    - ADD: carry out of bit 31.
    - SUB: NOT borrow, i.e. 1 when a>=b unsigned.
    - All other ops: 0.
  - V:
    - ADD: a[31]==b[31] && result[31]!=a[31].
    - SUB: a[31]!=b[31] && result[31]!=a[31].
    - All other ops: 0.
- Arithmetic: two's complement, wrap modulo 2^32. SUB is implemented as a + ~b + 1 on the shared adder.
- Shift amounts of 0 return `a` unchanged. Amounts 31 and above still use only b[4:0].
- Inputs need not be held stable beyond the sampling edge.

Decomposition:
- Package `alu_pkg` holds:
  - opcode localparams (OP_ADD..OP_PASSB);
  - flag index constants (FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0).
- One natural sub-module, `alu_addsub`, covers the shared adder used by ADD/SUB/SLT/SLTU:
  - inputs a, b, sub;
  - outputs sum, carry, overflow.
- Result mux, flag logic and output registers stay in alu_32.

Test Plan:
- Reset: drive rst=1 for 2 cycles with a=7, b=2, op=00 -> out=0, S=0 during reset. The first edge after release gives out=9.
- Op sweep with a=7, b=2 (one op per cycle, check 1 cycle later):
  - ADD=9, SUB=5, AND=2, OR=7, XOR=5, NOR=FFFFFFF8
  - SLL=1C, SRL=1, SRA=1, SLT=0, SLTU=0, PASSA=7, PASSB=2
  - undefined op 3F -> out 0, Z=1
- Carry: ADD a=FFFFFFFF, b=FFFFFFFF -> out=FFFFFFFE, C=1, V=0, N=1, Z=0.
- Overflow: ADD a=7FFFFFFF, b=1 -> out=80000000, V=1, N=1. SUB a=80000000, b=1 -> out=7FFFFFFF, V=1, C=1.
- Zero: ADD a=0, b=0 -> out=0, Z=1, C=0. SUB a=5, b=5 -> Z=1, C=1.
- Negative/signed: ADD a=80000004, b=1 -> out=80000005, N=1. SRA a=80000000, b=4 -> F8000000. SLT a=80000000, b=1 -> 1. SLTU with the same operands -> 0.
